// File: rtl/uart_pkg.sv
// uart_pkg
// Constants and state encoding shared by the UART receiver and transmitter.
//   OVERSAMPLE : baud_tick pulses per bit period
//   MID_SAMPLE : tick count at which the start bit is re-checked (bit centre)
//   DATA_BITS  : payload bits per frame, LSB first
//   uart_state_e : common frame-sequencer state encoding
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;
   localparam int DATA_BITS  = 8;

   // Counter/index compare values derived from the constants above
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);
   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } uart_state_e;

   // Shift a new serial bit into the MSB; after DATA_BITS shifts the first
   // bit received sits in bit 0 (LSB-first line order).
   function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
      return {b, sr[7:1]};
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Multi-flop synchroniser for the asynchronous UART line. Resets to 1 so the
// line reads as idle while reset is held.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   rx    : asynchronous serial input
//   rx_s  : synchronised serial line (SYNC_STAGES clk of latency)
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rx_s
);

   logic [SYNC_STAGES-1:0] sync_r;

   // Shift the raw line through the flop chain every clk
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 16x-oversampling UART receiver, 8 data bits, no parity, one stop bit.
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   baud_tick : one-clk pulse at 16x baud; the frame sequencer only moves on it
//   rx        : asynchronous serial line, idles high
//   rx_data   : last correctly framed byte, held until the next good frame
//   rx_done   : one-clk pulse when rx_data has just been updated
//   rx_busy   : high from start-bit detection until the frame ends
//   frame_err : one-clk pulse when the stop bit is sampled low
module uart_receiver
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_tick,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_busy,
   output logic       frame_err
);

   logic        rx_s;
   uart_state_e state_r,  state_nxt_s;
   logic [3:0]  cnt_r,    cnt_nxt_s;
   logic [2:0]  bit_r,    bit_nxt_s;
   logic [7:0]  shift_r,  shift_nxt_s;
   logic [7:0]  data_r,   data_nxt_s;
   logic        done_r,   done_nxt_s;
   logic        err_r,    err_nxt_s;
   logic        busy_r,   busy_nxt_s;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .rx_s  (rx_s)
   );

   // Frame sequencer next-state; pulses default low so they last one clk
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      bit_nxt_s   = bit_r;
      shift_nxt_s = shift_r;
      data_nxt_s  = data_r;
      done_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      busy_nxt_s  = busy_r;
      if (baud_tick) begin
         case (state_r)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_nxt_s = ST_START;
                  cnt_nxt_s   = 4'd0;
                  busy_nxt_s  = 1'b1;
               end else begin
                  busy_nxt_s  = 1'b0;
               end
            end
            ST_START: begin
               // Re-check the start bit at its centre to reject glitches
               if (cnt_r == TICK_MID) begin
                  if (!rx_s) begin
                     state_nxt_s = ST_DATA;
                     cnt_nxt_s   = 4'd0;
                     bit_nxt_s   = 3'd0;
                  end else begin
                     state_nxt_s = ST_IDLE;
                     busy_nxt_s  = 1'b0;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + 4'd1;
               end
            end
            ST_DATA: begin
               // Counter restarts at each sample, so samples stay at bit centres
               if (cnt_r == TICK_LAST) begin
                  shift_nxt_s = shift_in(shift_r, rx_s);
                  cnt_nxt_s   = 4'd0;
                  if (bit_r == BIT_LAST) begin
                     state_nxt_s = ST_STOP;
                  end else begin
                     bit_nxt_s = bit_r + 3'd1;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + 4'd1;
               end
            end
            ST_STOP: begin
               if (cnt_r == TICK_LAST) begin
                  if (rx_s) begin
                     data_nxt_s  = shift_r;
                     done_nxt_s  = 1'b1;
                     state_nxt_s = ST_IDLE;
                     busy_nxt_s  = 1'b0;
                  end else begin
                     err_nxt_s   = 1'b1;
                     state_nxt_s = ST_WAIT_HIGH;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + 4'd1;
               end
            end
            ST_WAIT_HIGH: begin
               // Line break: a low line here must not be taken as a new start
               if (rx_s) begin
                  state_nxt_s = ST_IDLE;
                  busy_nxt_s  = 1'b0;
               end else begin
                  busy_nxt_s  = 1'b1;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
               bit_nxt_s   = 3'd0;
               busy_nxt_s  = 1'b0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         data_r  <= 8'h00;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         bit_r   <= bit_nxt_s;
         shift_r <= shift_nxt_s;
         data_r  <= data_nxt_s;
         done_r  <= done_nxt_s;
         err_r   <= err_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

   assign rx_data   = data_r;
   assign rx_done   = done_r;
   assign rx_busy   = busy_r;
   assign frame_err = err_r;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver: a vector table of frames plus
// hand-written sequences (false start, line break, reset mid-frame).
// Expected pulses are queued as frames are driven and checked when the DUT
// pulses rx_done or frame_err, including data and detection-to-pulse latency.
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic       baud_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       frame_err;

   typedef struct {
      logic [7:0] data;
      bit         err;
      int         start_tick;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      int         skew;
      int         gap;
   } vec_t;

   exp_t       sb_q[$];
   vec_t       vecs[10];
   int         tests = 0;
   int         fails = 0;
   int         gtick = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] exp_last = 8'h00;

   uart_receiver #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_tick (baud_tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Return just after the n-th baud tick edge from now
   task automatic tick_wait(input int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clk);
         if (baud_tick) k++;
      end
      #2;
   endtask

   // Drive a full frame; start bit lengthened/shortened by skew ticks
   task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                             input int skew, input bit expect_it);
      exp_t e;
      e.start_tick = gtick;
      e.err        = !stop_ok;
      e.data       = stop_ok ? d : exp_last;
      if (expect_it) begin
         sb_q.push_back(e);
         if (stop_ok) exp_last = d;
      end
      rx = 1'b0;
      tick_wait(2);
      check("busy_in_frame", rx_busy, 1);
      tick_wait(14 + skew);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick_wait(16);
      end
      rx = stop_ok;
      tick_wait(16);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || rx_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue", sb_q.size(), 0);
      check("idle_busy", rx_busy, 0);
   endtask

   initial begin
      int         fell;
      int         done_before;
      logic [7:0] d5a;

      reset     = 1'b1;
      rx        = 1'b1;
      baud_tick = 1'b0;

      fork
         begin : baud_gen
            int ph;
            ph = 0;
            forever begin
               @(posedge clk);
               #1;
               ph        = (ph + 1) % 4;
               baud_tick = (ph == 0);
            end
         end
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (baud_tick) gtick++;
               if (rx_done && frame_err) check("pulse_exclusive", 1, 0);
               if (rx_done || frame_err) begin
                  if (sb_q.size() == 0) begin
                     check("unexpected_pulse", 1, 0);
                  end else begin
                     e = sb_q.pop_front();
                     check("pulse_kind_err", frame_err, e.err);
                     check("rx_data", rx_data, e.data);
                     check("latency_ticks", gtick - e.start_tick, 153);
                  end
                  done_cnt += rx_done;
                  err_cnt  += frame_err;
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_done", rx_done, 0);
      check("rst_rx_busy", rx_busy, 0);
      check("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      tick_wait(3);

      // Table of frames: back-to-back pair and a +/-3 tick skew sweep
      vecs[0] = '{8'hA5,  0, 4};
      vecs[1] = '{8'h00,  0, 0};
      vecs[2] = '{8'hFF,  0, 4};
      vecs[3] = '{8'h96, -3, 2};
      vecs[4] = '{8'h96, -2, 2};
      vecs[5] = '{8'h96, -1, 2};
      vecs[6] = '{8'h96,  0, 2};
      vecs[7] = '{8'h96,  1, 2};
      vecs[8] = '{8'h96,  2, 2};
      vecs[9] = '{8'h96,  3, 2};
      for (int i = 0; i < 10; i++) begin
         send_frame(vecs[i].data, 1'b1, vecs[i].skew, 1'b1);
         rx = 1'b1;
         if (vecs[i].gap > 0) tick_wait(vecs[i].gap);
      end
      wait_idle();
      check("table_done_count", done_cnt, 10);
      check("table_err_count", err_cnt, 0);
      check("table_last_data", rx_data, 8'h96);

      // False start: 4 low ticks, busy must drop at the 9th tick from here
      tick_wait(4);
      done_before = done_cnt;
      fell = 0;
      rx = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick_wait(1);
         if (k == 4) rx = 1'b1;
         if (k == 1) check("false_start_busy", rx_busy, 1);
         if (!rx_busy && fell == 0) fell = k;
      end
      check("false_start_release_tick", fell, 9);
      check("false_start_no_done", done_cnt, done_before);
      check("false_start_no_err", err_cnt, 0);

      // Stop bit low then line break, then a good frame
      send_frame(8'h3C, 1'b0, 0, 1'b1);
      tick_wait(40);
      check("break_busy", rx_busy, 1);
      check("break_err_count", err_cnt, 1);
      check("break_data_held", rx_data, 8'h96);
      rx = 1'b1;
      tick_wait(2);
      check("break_exit_busy", rx_busy, 0);
      tick_wait(3);
      send_frame(8'h81, 1'b1, 0, 1'b1);
      rx = 1'b1;
      wait_idle();
      check("after_break_data", rx_data, 8'h81);

      // Reset during data bit 4 of 0x5A
      tick_wait(3);
      done_before = done_cnt;
      d5a = 8'h5A;
      rx = 1'b0;
      tick_wait(16);
      for (int i = 0; i < 4; i++) begin
         rx = d5a[i];
         tick_wait(16);
      end
      rx = d5a[4];
      tick_wait(8);
      reset = 1'b1;
      #1;
      check("midrst_rx_data", rx_data, 8'h00);
      check("midrst_rx_busy", rx_busy, 0);
      check("midrst_rx_done", rx_done, 0);
      check("midrst_frame_err", frame_err, 0);
      rx = 1'b1;
      exp_last = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      tick_wait(20);
      check("post_rst_busy", rx_busy, 0);
      check("post_rst_no_pulse", done_cnt, done_before);
      send_frame(8'hC3, 1'b1, 0, 1'b1);
      rx = 1'b1;
      wait_idle();
      check("post_rst_data", rx_data, 8'hC3);
      check("final_err_count", err_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flip-flops in the rx input synchroniser (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port baud_tick  input  1  one-clk pulse at 16x the baud rate, from the shared baud generator.
REQ-005 SHALL have port rx  input  1  asynchronous UART line; idles high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-007 SHALL have port rx_done  output  1  one-clk pulse when rx_data has just been updated; used as the RX FIFO write strobe.
REQ-008 SHALL have port rx_busy  output  1  high from start-bit detection until the frame ends.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse when the stop bit is sampled low.

Function
REQ-010 SHALL pass rx through a SYNC_STAGES-deep synchroniser (rx_s) clocked every clk; all decisions use rx_s only.
REQ-011 SHALL advance the FSM only on clk edges where baud_tick=1; the synchroniser and pulse clearing run every clk.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a 4-bit tick counter and a 3-bit bit index.
REQ-013 In IDLE, when rx_s=0 on a tick: go to START, clear the tick counter, set rx_busy=1.
REQ-014 In START, on the tick where the counter equals 7 (the 8th tick after detection):
- rx_s=0: go to DATA, clear the counter and bit index.
- rx_s=1: false start; go to IDLE, set rx_busy=0, no pulse.
REQ-015 In DATA, on the tick where the counter equals 15, SHALL sample rx_s into the shift register MSB, shifting right (LSB first), then clear the counter; after bit index 7, go to STOP, otherwise increment the bit index.
REQ-016 In STOP, on the tick where the counter equals 15:
- rx_s=1: load rx_data from the shift register, pulse rx_done, go to IDLE.
- rx_s=0: leave rx_data unchanged, pulse frame_err, go to WAIT_HIGH.
REQ-017 In WAIT_HIGH (line break), SHALL stay until rx_s=1 on a tick, then go to IDLE; rx_busy SHALL remain 1 until IDLE is entered.
REQ-018 rx_done and frame_err SHALL be high for exactly one clk cycle, never together, and be cleared on the next clk regardless of baud_tick.
REQ-019 The counter SHALL increment by 1 on every tick not matched by REQ-014/015/016 and SHALL never wrap unobserved (4-bit, compare before increment).
REQ-020 Latency: rx_done SHALL assert on the 152nd baud_tick after the detection tick (8 + 8x16 + 16).
REQ-021 A falling edge of rx in START/DATA/STOP SHALL NOT restart the frame; a new start is detected only in IDLE.
REQ-022 Unused state encodings SHALL return to IDLE with rx_busy=0.

Reset
REQ-023 On reset SHALL force: state=IDLE, rx_data=0x00, rx_done=0, frame_err=0, rx_busy=0, counter=0, bit index=0, shift register=0, synchroniser flops=1 (line idle).
REQ-024 Reset mid-frame SHALL abandon the frame with no pulse; after release, a frame is accepted only from a fresh start-bit detection.

Structure
REQ-025 SHALL take OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8 and the shared UART state-encoding constants from package uart_pkg, common with the transmitter.
REQ-026 SHALL instantiate one sub-module, uart_rx_sync (parameterised SYNC_STAGES, reset value 1), for the synchroniser.

Verification
REQ-027 Send 0xA5 at 16x ticks, stop bit high -> one rx_done pulse, rx_data=0xA5, frame_err=0, rx_busy low afterwards.
REQ-028 Send 0x00 then 0xFF back-to-back with a single stop bit -> two rx_done pulses, rx_data 0x00 then 0xFF.
REQ-029 Drive rx low for 4 ticks, then high -> no rx_done, no frame_err, rx_busy returns to 0 on the 8th tick.
REQ-030 Send 0x3C with the stop bit low, hold rx low for 40 ticks, then send 0x81 -> frame_err pulse, rx_data stays at its prior value, 0x81 is then received correctly.
REQ-031 Assert reset during DATA bit 4 of 0x5A -> all outputs at reset values, no pulse; the following 0xC3 is received correctly.
REQ-032 Sweep the tick phase +/-3 ticks (line skew) on 0x96 -> rx_data=0x96 in every case.
